// File: rtl/count_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : count_sequencer_if
// Purpose  : Command/status bundle between the button front-end and the
//            run/pause/stop counter sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface count_sequencer_if #(
    parameter int CNT_W = 4
);
    logic             START;
    logic             STOP;
    logic             CLEAR;
    logic             MODE;
    logic [CNT_W-1:0] LIMIT;
    logic [CNT_W-1:0] COUNT;
    logic             TICK;
    logic             RUNNING;
    logic             DONE;

    // Front-end side: issues commands, observes status.
    modport master (
        output START, STOP, CLEAR, MODE, LIMIT,
        input  COUNT, TICK, RUNNING, DONE
    );

    // Sequencer side: consumes commands, reports status.
    modport slave (
        input  START, STOP, CLEAR, MODE, LIMIT,
        output COUNT, TICK, RUNNING, DONE
    );
endinterface
`default_nettype wire

// File: rtl/count_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : count_sequencer
// Purpose  : Run/pause/stop controller for the display up-counter. A gated
//            prescaler yields a one-cycle TICK enable; the counter runs
//            0..LIMIT in one-shot or auto-reload mode.
// Revision : 1.0 - initial release
// ============================================================================
module count_sequencer #(
    parameter int DIV_W = 23,
    parameter int CNT_W = 4
) (
    input  wire logic        CLK,
    input  wire logic        RESET,
    count_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   presc_q, presc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   limit_q, limit_d;
    logic               mode_q,  mode_d;
    logic               done_q,  done_d;
    logic               tick;

    // The tick is suppressed by STOP/CLEAR in the same cycle, so a pause
    // request never loses or duplicates a count step.
    assign tick = (state_q == ST_RUN) && (presc_q == '1) && !bus.STOP && !bus.CLEAR;

    // Next-state computation; CLEAR outranks STOP, which outranks START.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        count_d = count_q;
        limit_d = limit_q;
        mode_d  = mode_q;
        done_d  = 1'b0;

        if (bus.CLEAR) begin
            state_d = ST_IDLE;
            count_d = '0;
            presc_d = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    // STOP is meaningless outside RUN, so START still applies.
                    if (bus.START) begin
                        limit_d = bus.LIMIT;
                        mode_d  = bus.MODE;
                        count_d = '0;
                        presc_d = '0;
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.STOP) begin
                        state_d = ST_PAUSE;
                    end else begin
                        presc_d = presc_q + DIV_W'(1);
                        if (tick) begin
                            if (count_q != limit_q) begin
                                count_d = count_q + CNT_W'(1);
                            end else begin
                                done_d = 1'b1;
                                if (mode_q) begin
                                    count_d = '0;
                                end else begin
                                    state_d = ST_DONE;
                                end
                            end
                        end
                    end
                end
                ST_PAUSE: begin
                    // Resume keeps count, prescaler phase and latched settings.
                    if (bus.START) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            count_q <= '0;
            limit_q <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            count_q <= count_d;
            limit_q <= limit_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    assign bus.COUNT   = count_q;
    assign bus.TICK    = tick;
    assign bus.RUNNING = (state_q == ST_RUN);
    assign bus.DONE    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_count_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_count_sequencer
// Purpose  : Self-checking bench for count_sequencer: directed scenarios with
//            literal expectations plus randomized commands against a
//            behavioural model of the run/pause/count rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_count_sequencer;

    localparam int DIV_W  = 2;
    localparam int CNT_W  = 4;
    localparam int PERIOD = 1 << DIV_W;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    count_sequencer_if #(.CNT_W(CNT_W)) bus ();

    count_sequencer #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: activity flags, RUN-cycle phase within a tick period,
    // count and the settings captured at the last fresh start.
    bit m_running  = 0;
    bit m_paused   = 0;
    bit m_finished = 0;
    int m_phase    = 0;
    int m_count    = 0;
    int m_limit    = 0;
    bit m_mode     = 0;
    bit m_done     = 0;

    task automatic m_reset();
        m_running = 0; m_paused = 0; m_finished = 0;
        m_phase = 0; m_count = 0; m_limit = 0; m_mode = 0; m_done = 0;
    endtask

    task automatic m_step();
        m_done = 0;
        if (bus.CLEAR) begin
            m_running = 0; m_paused = 0; m_finished = 0;
            m_count = 0; m_phase = 0;
        end else if (m_running) begin
            if (bus.STOP) begin
                m_running = 0; m_paused = 1;
            end else begin
                m_phase = m_phase + 1;
                if (m_phase == PERIOD) begin
                    m_phase = 0;
                    if (m_count < m_limit) begin
                        m_count = m_count + 1;
                    end else begin
                        m_done = 1;
                        if (m_mode) m_count = 0;
                        else begin m_running = 0; m_finished = 1; end
                    end
                end
            end
        end else if (bus.START) begin
            if (m_paused) begin
                m_paused = 0; m_running = 1;
            end else begin
                m_limit = int'(bus.LIMIT); m_mode = bus.MODE;
                m_count = 0; m_phase = 0;
                m_running = 1; m_finished = 0;
            end
        end
    endtask

    // Model advances on the same events as the design.
    always @(posedge CLK or posedge RESET) begin
        if (RESET) m_reset();
        else       m_step();
    end

    task automatic check(input string name, input int actual, input int expected);
        checks = checks + 1;
        if (actual != expected) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        check("count",   int'(bus.COUNT), m_count);
        check("running", int'(bus.RUNNING), int'(m_running));
        check("done",    int'(bus.DONE), int'(m_done));
        check("tick",    int'(bus.TICK),
              int'(m_running && (m_phase == PERIOD - 1) && !bus.STOP && !bus.CLEAR));
    end

    // Advance one edge and return 1 time unit after it.
    task automatic step(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic cmd_start(input logic [CNT_W-1:0] lim, input logic md);
        bus.LIMIT = lim; bus.MODE = md; bus.START = 1'b1;
        step();
        bus.START = 1'b0;
    endtask

    task automatic pulse_stop();
        bus.STOP = 1'b1; step(); bus.STOP = 1'b0;
    endtask

    task automatic pulse_clear();
        bus.CLEAR = 1'b1; step(); bus.CLEAR = 1'b0;
    endtask

    initial begin
        bus.START = 0; bus.STOP = 0; bus.CLEAR = 0; bus.MODE = 0; bus.LIMIT = '0;

        // Reset state.
        #3;
        check("rst_count", int'(bus.COUNT), 0);
        check("rst_running", int'(bus.RUNNING), 0);
        step(2);
        RESET = 1'b0;
        step(2);

        // One-shot LIMIT=3: counts at edges 4,8,12, terminal at 16.
        cmd_start(4'd3, 1'b0);          // edge 0
        step(4);  check("os_c1", int'(bus.COUNT), 1);
        step(8);  check("os_c3", int'(bus.COUNT), 3);
        step(4);  check("os_done", int'(bus.DONE), 1);
                  check("os_run_drop", int'(bus.RUNNING), 0);
        step(1);  check("os_done_gone", int'(bus.DONE), 0);
                  check("os_hold", int'(bus.COUNT), 3);

        // Auto-reload LIMIT=15: wrap at edge 64, next count at 68.
        cmd_start(4'd15, 1'b1);
        step(64); check("ar_wrap", int'(bus.COUNT), 0);
                  check("ar_done", int'(bus.DONE), 1);
                  check("ar_run", int'(bus.RUNNING), 1);
        step(4);  check("ar_next", int'(bus.COUNT), 1);
        pulse_clear();
        check("clr_count", int'(bus.COUNT), 0);

        // Pause with prescaler at 2, resume 10 cycles later.
        cmd_start(4'd7, 1'b0);
        step(2);
        pulse_stop();
        step(9);
        check("pause_run", int'(bus.RUNNING), 0);
        bus.START = 1'b1; step(); bus.START = 1'b0;
        step(1);  check("resume_c0", int'(bus.COUNT), 0);
        step(1);  check("resume_c1", int'(bus.COUNT), 1);

        // START+STOP in RUN pauses; CLEAR+START in PAUSE goes idle.
        bus.START = 1'b1; bus.STOP = 1'b1; step(); bus.START = 1'b0; bus.STOP = 1'b0;
        check("ss_pause", int'(bus.RUNNING), 0);
        bus.START = 1'b1; bus.CLEAR = 1'b1; step(); bus.START = 1'b0; bus.CLEAR = 1'b0;
        check("cs_idle_count", int'(bus.COUNT), 0);
        step(3);  check("cs_idle_run", int'(bus.RUNNING), 0);

        // LIMIT=0 one-shot: done after the first tick with COUNT=0.
        cmd_start(4'd0, 1'b0);
        step(4);  check("l0_done", int'(bus.DONE), 1);
                  check("l0_count", int'(bus.COUNT), 0);
        // Restart from DONE with a new limit; change LIMIT mid-run.
        cmd_start(4'd3, 1'b0);
        bus.LIMIT = 4'd9;
        step(16); check("lim_latched_done", int'(bus.DONE), 1);
                  check("lim_latched_count", int'(bus.COUNT), 3);

        // Asynchronous reset mid-run at COUNT=5.
        cmd_start(4'd9, 1'b0);
        step(21);
        check("pre_rst_count", int'(bus.COUNT), 5);
        #1 RESET = 1'b1;
        #1;
        check("arst_count", int'(bus.COUNT), 0);
        check("arst_running", int'(bus.RUNNING), 0);
        step(1);
        RESET = 1'b0;
        step(6);
        check("post_rst_idle", int'(bus.RUNNING), 0);

        // Randomized commands against the model.
        for (int i = 0; i < 3000; i++) begin
            bus.START = ($urandom_range(0, 7) == 0);
            bus.STOP  = ($urandom_range(0, 15) == 0);
            bus.CLEAR = ($urandom_range(0, 63) == 0);
            bus.MODE  = $urandom_range(0, 1);
            bus.LIMIT = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                    : 4'($urandom_range(0, 4));
            if ($urandom_range(0, 499) == 0) begin
                #1 RESET = 1'b1;
                step(1);
                RESET = 1'b0;
            end else begin
                step(1);
            end
        end
        bus.START = 0; bus.STOP = 0; bus.CLEAR = 0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
